// File: rtl/lyr1_pkg.sv
// Shared constants and state encoding for the layer-1 neuron sequencer.
package lyr1_pkg;

   localparam int NW     = 9;
   localparam int ADDR_W = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_CALC  = 3'd3,
      S_OUT   = 3'd4,
      S_FIN   = 3'd5
   } state_t;

endpackage

// File: rtl/maclyr1.sv
// Nine-tap multiply-accumulate with bias; every product and the running sum
// wrap modulo 2^DW, so there is no saturation anywhere.
module maclyr1
   import lyr1_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic [NW*DW-1:0] d,
   input  logic [NW*DW-1:0] w,
   input  logic [DW-1:0]    b,
   output logic [DW-1:0]    y
);

   logic [DW-1:0] acc;

   always_comb begin
      acc = b;
      for (int i = 0; i < NW; i++) begin
         acc = acc + d[i*DW +: DW] * w[i*DW +: DW];
      end
      y = acc;
   end

endmodule

// File: rtl/lyr1_sched.sv
// Sequences one 3x3 window through N_NEURON layer-1 neurons: fetch weights,
// load them, run the MAC, then hand each result to the consumer in order.
module lyr1_sched
   import lyr1_pkg::*;
#(
   parameter int N_NEURON = 4,
   parameter int DW       = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [NW*DW-1:0]     pix,
   output logic [ADDR_W-1:0]    w_addr,
   output logic                 w_en,
   input  logic [(NW+1)*DW-1:0] w_rdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        out_data,
   output logic [ADDR_W-1:0]    out_idx,
   output logic                 busy,
   output logic                 done,
   output state_t               dbg_state
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_NEURON - 1);

   state_t              state;
   logic [ADDR_W-1:0]   idx;
   logic [NW*DW-1:0]    win;
   logic [NW*DW-1:0]    wts;
   logic [DW-1:0]       bias;
   logic [DW-1:0]       mac_y;

   maclyr1 #(.DW(DW)) u_mac (
      .d (win),
      .w (wts),
      .b (bias),
      .y (mac_y)
   );

   // Handshake: a result transfers on a rising edge where out_valid and
   // out_ready are both 1; out_valid, out_data and out_idx hold until then,
   // and out_ready may be raised before out_valid.
   // All outputs are registered, so out_valid and w_en never see start or
   // out_ready combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         idx       <= '0;
         win       <= '0;
         wts       <= '0;
         bias      <= '0;
         w_addr    <= '0;
         w_en      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         w_en <= 1'b0;
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  win    <= pix;
                  idx    <= '0;
                  w_addr <= '0;
                  w_en   <= 1'b1;
                  busy   <= 1'b1;
                  state  <= S_FETCH;
               end
            end
            S_FETCH: begin
               state <= S_LOAD;
            end
            S_LOAD: begin
               wts   <= w_rdata[NW*DW-1:0];
               bias  <= w_rdata[(NW+1)*DW-1 -: DW];
               state <= S_CALC;
            end
            S_CALC: begin
               out_data  <= mac_y;
               out_idx   <= idx;
               out_valid <= 1'b1;
               state     <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (idx != LAST) begin
                     idx    <= idx + 1'b1;
                     w_addr <= idx + 1'b1;
                     w_en   <= 1'b1;
                     state  <= S_FETCH;
                  end else begin
                     done  <= 1'b1;
                     state <= S_FIN;
                  end
               end
            end
            S_FIN: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy      <= 1'b0;
               out_valid <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_lyr1_sched.sv
// Scoreboard bench for lyr1_sched: a 4-neuron instance for the main frames and
// a 1-neuron instance for the single-result case.
module tb_lyr1_sched;
   import lyr1_pkg::*;

   localparam int DW = 16;
   localparam int N  = 4;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                 start, start1;
   logic [NW*DW-1:0]     pix;
   logic [ADDR_W-1:0]    w_addr, w_addr1;
   logic                 w_en, w_en1;
   logic [(NW+1)*DW-1:0] w_rdata, w_rdata1;
   logic                 out_valid, out_valid1;
   logic                 out_ready, out_ready1;
   logic [DW-1:0]        out_data, out_data1;
   logic [ADDR_W-1:0]    out_idx, out_idx1;
   logic                 busy, busy1, done, done1;
   state_t               dbg_state, dbg_state1;

   lyr1_sched #(.N_NEURON(N), .DW(DW)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pix(pix),
      .w_addr(w_addr), .w_en(w_en), .w_rdata(w_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .busy(busy), .done(done), .dbg_state(dbg_state)
   );

   lyr1_sched #(.N_NEURON(1), .DW(DW)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .pix(pix),
      .w_addr(w_addr1), .w_en(w_en1), .w_rdata(w_rdata1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .out_idx(out_idx1), .busy(busy1), .done(done1), .dbg_state(dbg_state1)
   );

   // weight memory: data one cycle after the read enable
   logic [(NW+1)*DW-1:0] mem [0:15];
   always @(posedge clk) begin
      if (w_en)  w_rdata  <= mem[w_addr];
      if (w_en1) w_rdata1 <= mem[w_addr1];
   end

   int checks = 0;
   int errors = 0;
   logic [19:0] exp_q [$];
   logic [DW-1:0] first_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] golden(input logic [NW*DW-1:0] p,
                                            input logic [(NW+1)*DW-1:0] wr);
      int unsigned s;
      s = 32'(wr[(NW+1)*DW-1 -: DW]);
      for (int i = 0; i < NW; i++) begin
         s = s + 32'(p[i*DW +: DW]) * 32'(wr[i*DW +: DW]);
      end
      return s[DW-1:0];
   endfunction

   function automatic logic [NW*DW-1:0] rand_pix();
      logic [NW*DW-1:0] p;
      for (int i = 0; i < NW; i++) p[i*DW +: DW] = 16'($urandom);
      return p;
   endfunction

   task automatic fill_mem(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                           input logic [DW-1:0] b2, input logic [DW-1:0] b3);
      logic [DW-1:0] b [4];
      b = '{b0, b1, b2, b3};
      for (int n = 0; n < 16; n++) begin
         for (int i = 0; i < NW; i++) mem[n][i*DW +: DW] = 16'($urandom_range(0, 16'hFFFF));
         mem[n][(NW+1)*DW-1 -: DW] = (n < 4) ? b[n] : 16'($urandom);
      end
   endtask

   // driver + monitor for one frame on the 4-neuron instance
   task automatic run_frame(input logic [NW*DW-1:0] p, input int stall_idx,
                            input bit restart, input bit abort, output int cyc_done);
      int cyc, pops, wen_cnt, stall_left, stalled;
      bit seen_done, have_snap;
      logic [19:0] snap, item;
      exp_q.delete();
      for (int n = 0; n < N; n++) exp_q.push_back({4'(n), golden(p, mem[n])});
      cyc = 0; pops = 0; wen_cnt = 0; stall_left = 10; stalled = 0;
      seen_done = 0; have_snap = 0; snap = '0; cyc_done = -1;
      @(posedge clk); #1;
      pix = p; start = 1'b1; out_ready = (stall_idx == 0) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (!seen_done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (w_en) wen_cnt++;
         if (done) begin seen_done = 1; cyc_done = cyc; end
         if (abort && dbg_state == S_CALC && pops == 2) begin
            rst_n = 1'b0;
            #1;
            check("abort_valid", out_valid, 1'b0);
            check("abort_busy", busy, 1'b0);
            check("abort_state", dbg_state, S_IDLE);
            check("abort_data", out_data, '0);
            check("abort_idx", out_idx, '0);
            repeat (3) begin
               @(negedge clk);
               check("abort_nodone", done, 1'b0);
            end
            @(posedge clk); #1;
            rst_n = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            check("abort_idle", busy, 1'b0);
            exp_q.delete();
            break;
         end
         if (out_valid) begin
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  check("sb_extra", pops + 1, N);
               end else begin
                  item = exp_q.pop_front();
                  check("sb_idx", out_idx, item[19:16]);
                  check("sb_data", out_data, item[15:0]);
                  if (out_idx == 0) first_data = out_data;
               end
               pops++;
            end else begin
               stalled++;
               stall_left--;
               check("stall_wen", w_en, 1'b0);
               if (!have_snap) begin
                  snap = {out_idx, out_data};
                  have_snap = 1;
                  check("stall_idx", out_idx, stall_idx);
               end else begin
                  check("stall_hold", {out_idx, out_data}, snap);
               end
            end
         end
         @(posedge clk); #1;
         out_ready = !(pops == stall_idx && stall_left > 0);
         start = restart && (cyc == 5 || cyc == 12);
         if (restart && cyc == 5) pix = ~p;
      end
      start = 1'b0;
      out_ready = 1'b1;
      if (abort) begin
         check("abort_pops", pops, 2);
      end else begin
         check("frame_done_seen", seen_done, 1'b1);
         check("frame_results", pops, N);
         check("frame_sb_empty", exp_q.size(), 0);
         check("frame_wen_cnt", wen_cnt, N);
         if (stall_idx >= 0) check("stall_cycles", stalled, 10);
      end
   endtask

   task automatic run_single(input logic [NW*DW-1:0] p);
      int hs, got;
      bit seen;
      hs = -10; got = 0; seen = 0;
      @(posedge clk); #1;
      pix = p; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
         @(negedge clk);
         if (done1) begin
            seen = 1;
            check("n1_done_cycle", cyc, hs + 1);
         end
         if (out_valid1) begin
            got++;
            hs = cyc;
            check("n1_idx", out_idx1, 0);
            check("n1_data", out_data1, golden(p, mem[0]));
         end
      end
      check("n1_done_seen", seen, 1'b1);
      check("n1_count", got, 1);
   endtask

   initial begin
      int c;
      logic [NW*DW-1:0] p;
      start = 0; start1 = 0; pix = '0; out_ready = 1; out_ready1 = 1;
      first_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", out_valid, 1'b0);
      check("rst_data", out_data, '0);
      check("rst_idx", out_idx, '0);
      check("rst_wen", w_en, 1'b0);
      check("rst_waddr", w_addr, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_state", dbg_state, S_IDLE);
      rst_n = 1'b1;

      // zero window: results are the biases; 17 cycles start to done
      fill_mem(16'h1234, 16'h0001, 16'hFFFF, 16'h8000);
      run_frame('0, -1, 0, 0, c);
      check("bias_done_latency", c, 17);

      // consumer stall on neuron 1
      fill_mem(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      run_frame(rand_pix(), 1, 0, 0, c);
      check("stall_done_latency", c, 27);

      // start while busy with a changed window
      run_frame(rand_pix(), -1, 1, 0, c);
      check("restart_done_latency", c, 17);

      // wrapping sum: 0x7FFF + 2*3
      fill_mem(16'h7FFF, 16'($urandom), 16'($urandom), 16'($urandom));
      for (int i = 0; i < NW; i++) mem[0][i*DW +: DW] = '0;
      mem[0][DW-1:0] = 16'h0003;
      p = rand_pix();
      p[DW-1:0] = 16'h0002;
      run_frame(p, -1, 0, 0, c);
      check("wrap_value", first_data, 16'h8005);

      // reset during CALC of neuron 2, then the same frame again
      p = rand_pix();
      run_frame(p, -1, 0, 1, c);
      run_frame(p, -1, 0, 0, c);
      check("rerun_done_latency", c, 17);

      // single-neuron instance
      run_single(rand_pix());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
